countdown_timer: RTL and testbench

Two-digit-minute, two-digit-second BCD countdown timer for the FPGA clock. Pairs with the up-counting minute/second chain: it counts down from a loaded mm:ss value to 00:00, then raises a timed alarm. It takes the same 1 Hz enable pulse as the time-of-day counters. Its BCD outputs feed the display mux directly.

---
 rtl/countdown_timer_pkg.sv | 20 ++
 rtl/countdown_timer_bcd_down60.sv | 47 ++++
 rtl/countdown_timer.sv | 112 +++++++++++
 tb/tb_countdown_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared encodings and BCD limits for the mm:ss countdown timer.
// State values are fixed so the debug port reads the same across builds.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX_UNIT = 4'h9;
    localparam logic [3:0] BCD_MAX_TEN  = 4'h5;

    // A two-digit 00..59 BCD value: units digit <= 9, tens digit <= 5.
    function automatic logic bcd60_valid(input logic [7:0] v);
        return (v[3:0] <= BCD_MAX_UNIT) && (v[7:4] <= BCD_MAX_TEN);
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down60.sv
// Two-digit BCD down-counter, 59..00, with synchronous load and borrow-out.
// BRW flags the cycle in which an enabled count at 00 wraps to 59.
module bcd_down60
    import countdown_timer_pkg::*;
(
    input  logic       CP,
    input  logic       reset,
    input  logic       EN,
    input  logic       load,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       BRW
);

    logic [3:0] unit_q, unit_d;
    logic [3:0] ten_q, ten_d;

    always_comb begin
        unit_d = unit_q;
        ten_d  = ten_q;
        if (load) begin
            unit_d = D[3:0];
            ten_d  = D[7:4];
        end else if (EN) begin
            if (unit_q == 4'd0) begin
                unit_d = BCD_MAX_UNIT;
                ten_d  = (ten_q == 4'd0) ? BCD_MAX_TEN : ten_q - 4'd1;
            end else begin
                unit_d = unit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            unit_q <= 4'd0;
            ten_q  <= 4'd0;
        end else begin
            unit_q <= unit_d;
            ten_q  <= ten_d;
        end
    end

    assign Q   = {ten_q, unit_q};
    assign BRW = (Q == 8'h00) && EN;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer: command arbitration, FSM, zero detect and
// the alarm tick counter around two cascaded bcd_down60 digit pairs.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int ALARM_TICKS = 10
) (
    input  logic       CP,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(ALARM_TICKS + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acnt_q, acnt_d;
    logic             done_q, done_d;

    logic load_ok, stop_ok, start_ok, tick_run, tick_alarm;
    logic is_zero, is_one, sec_brw, min_brw;

    assign is_zero = (min == 8'h00) && (sec == 8'h00);
    assign is_one  = (min == 8'h00) && (sec == 8'h01);

    // Priority load > stop > start > tick; a command that cannot act in the
    // current state (or an invalid preset) lets the next one through.
    assign load_ok    = load && bcd60_valid(load_min) && bcd60_valid(load_sec)
                        && (state_q != ST_RUN);
    assign stop_ok    = !load_ok && stop
                        && ((state_q == ST_RUN) || (state_q == ST_ALARM));
    assign start_ok   = !load_ok && !stop_ok && start && !is_zero
                        && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    assign tick_run   = !stop_ok && tick && (state_q == ST_RUN);
    assign tick_alarm = !load_ok && !stop_ok && tick && (state_q == ST_ALARM);

    bcd_down60 u_sec (
        .CP    (CP),
        .reset (reset),
        .EN    (tick_run),
        .load  (load_ok),
        .D     (load_sec),
        .Q     (sec),
        .BRW   (sec_brw)
    );

    bcd_down60 u_min (
        .CP    (CP),
        .reset (reset),
        .EN    (sec_brw),
        .load  (load_ok),
        .D     (load_min),
        .Q     (min),
        .BRW   (min_brw)
    );

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        done_d  = 1'b0;
        if (load_ok) begin
            state_d = ST_IDLE;
            acnt_d  = '0;
        end else if (stop_ok) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_IDLE;
            acnt_d  = '0;
        end else if (start_ok) begin
            state_d = ST_RUN;
        end else if (tick_run && (is_one || min_brw)) begin
            // min_brw can only fire from 00:00, which RUN never holds; it
            // parks the timer in ALARM instead of letting it run on.
            state_d = ST_ALARM;
            acnt_d  = '0;
            done_d  = 1'b1;
        end else if (tick_alarm) begin
            if (acnt_q == CNT_W'(ALARM_TICKS - 1)) begin
                state_d = ST_IDLE;
                acnt_d  = '0;
            end else begin
                acnt_d = acnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
        end
    end

    assign running   = (state_q == ST_RUN);
    assign alarm     = (state_q == ST_ALARM);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a seconds-based reference model
// pushes expected outputs per driven cycle; they are popped after each edge.
module tb_countdown_timer;

    localparam int ALARM_TICKS = 10;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_ALARM = 3;

    logic       cp = 1'b0;
    logic       reset, tick, start, stop, load;
    logic [7:0] load_min, load_sec;
    logic [7:0] min_w, sec_w;
    logic       running_w, done_w, alarm_w;
    logic [1:0] dbg_state_w;

    countdown_timer #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .CP        (cp),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .min       (min_w),
        .sec       (sec_w),
        .running   (running_w),
        .done      (done_w),
        .alarm     (alarm_w),
        .dbg_state (dbg_state_w)
    );

    always #5 cp = ~cp;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    // {state[1:0], min[7:0], sec[7:0], running, done, alarm}
    logic [20:0] exp_q[$];

    int m_state, m_val, m_acnt;
    bit m_done;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[3:0] < 4'd10) && (b[7:4] < 4'd6);
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_val   = 0;
        m_acnt  = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input bit t, input bit st, input bit sp, input bit ld,
                              input logic [7:0] lm, input logic [7:0] ls);
        m_done = 0;
        if (ld && bcd_ok(lm) && bcd_ok(ls) && m_state != S_RUN) begin
            m_val   = from_bcd(lm) * 60 + from_bcd(ls);
            m_state = S_IDLE;
            m_acnt  = 0;
        end else if (sp && (m_state == S_RUN || m_state == S_ALARM)) begin
            m_state = (m_state == S_RUN) ? S_PAUSE : S_IDLE;
            m_acnt  = 0;
        end else if (st && (m_state == S_IDLE || m_state == S_PAUSE) && m_val != 0) begin
            m_state = S_RUN;
        end else if (t && m_state == S_RUN) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
                m_state = S_ALARM;
                m_acnt  = 0;
                m_done  = 1;
            end
        end else if (t && m_state == S_ALARM) begin
            m_acnt++;
            if (m_acnt == ALARM_TICKS) begin
                m_state = S_IDLE;
                m_acnt  = 0;
            end
        end
    endtask

    task automatic push_expected();
        exp_q.push_back({2'(m_state), to_bcd(m_val / 60), to_bcd(m_val % 60),
                         m_state == S_RUN, m_done, m_state == S_ALARM});
    endtask

    task automatic compare_outputs();
        logic [20:0] e;
        check_eq("exp_q_depth", exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_eq("state",   dbg_state_w, e[20:19]);
        check_eq("min",     min_w,       e[18:11]);
        check_eq("sec",     sec_w,       e[10:3]);
        check_eq("running", running_w,   e[2]);
        check_eq("done",    done_w,      e[1]);
        check_eq("alarm",   alarm_w,     e[0]);
        done_seen += int'(done_w);
    endtask

    task automatic step(input bit t, input bit st, input bit sp, input bit ld,
                        input logic [7:0] lm, input logic [7:0] ls);
        @(negedge cp);
        tick = t; start = st; stop = sp; load = ld;
        load_min = lm; load_sec = ls;
        model_step(t, st, sp, ld, lm, ls);
        push_expected();
        @(posedge cp);
        #1;
        compare_outputs();
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 8'($urandom), 8'($urandom));
    endtask

    task automatic do_tick();
        repeat ($urandom_range(0, 2)) idle_cycle();
        step(1, 0, 0, 0, 8'($urandom), 8'($urandom));
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        step(0, 0, 0, 1, lm, ls);
    endtask

    task automatic do_start();
        step(0, 1, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_stop();
        step(0, 0, 1, 0, 8'h00, 8'h00);
    endtask

    initial begin
        reset = 1'b1; tick = 0; start = 0; stop = 0; load = 0;
        load_min = 8'h00; load_sec = 8'h00;
        model_reset();
        #12;
        push_expected();
        compare_outputs();
        @(negedge cp);
        reset = 1'b0;

        // Full countdown 01:05 -> 00:00.
        do_load(8'h01, 8'h05);
        do_start();
        done_seen = 0;
        repeat (65) do_tick();
        check_eq("done_pulses", done_seen, 1);
        check_eq("alarm_at_zero", alarm_w, 1);

        // Alarm times out after ALARM_TICKS ticks.
        repeat (ALARM_TICKS) do_tick();
        check_eq("alarm_timeout", alarm_w, 0);

        // Alarm silenced by stop after 3 ticks, then by load.
        do_load(8'h00, 8'h02);
        do_start();
        repeat (2) do_tick();
        repeat (3) do_tick();
        do_stop();
        check_eq("alarm_stop", alarm_w, 0);
        do_load(8'h00, 8'h01);
        do_start();
        do_tick();
        do_tick();
        do_load(8'h00, 8'h03);
        check_eq("alarm_load_sec", sec_w, 8'h03);

        // Pause / resume with start coincident with tick.
        do_load(8'h00, 8'h30);
        do_start();
        repeat (5) do_tick();
        do_stop();
        repeat (4) do_tick();
        step(1, 1, 0, 0, 8'h00, 8'h00);
        check_eq("resume_sec", sec_w, 8'h25);
        check_eq("resume_running", running_w, 1);
        do_tick();
        check_eq("resume_next_sec", sec_w, 8'h24);

        // Invalid presets, zero preset.
        do_stop();
        do_load(8'h6A, 8'h00);
        do_load(8'h05, 8'h0A);
        do_load(8'h00, 8'h60);
        check_eq("invalid_hold", sec_w, 8'h24);
        do_load(8'h00, 8'h00);
        do_start();
        check_eq("zero_start_idle", running_w, 0);

        // Load ignored in RUN; load+stop+start together from PAUSE.
        do_load(8'h00, 8'h45);
        do_start();
        do_tick();
        do_load(8'h00, 8'h10);
        do_tick();
        do_stop();
        step(0, 1, 1, 1, 8'h00, 8'h12);
        check_eq("multi_cmd_sec", sec_w, 8'h12);

        // Asynchronous reset mid-count at 00:42.
        do_load(8'h00, 8'h50);
        do_start();
        repeat (8) do_tick();
        check_eq("pre_reset_sec", sec_w, 8'h42);
        @(negedge cp);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare_outputs();
        @(negedge cp);
        reset = 1'b0;

        // Random command mix with small presets so ALARM is reached often.
        repeat (400) begin
            logic [7:0] lm, ls;
            lm = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            ls = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 10))};
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, lm, ls);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
